// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

  // Width of one UART byte lane.
  localparam int BYTE_W = 8;

  // Arbiter FSM: IDLE picks an owner, XFER streams the owner's packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Successor of a requester index on the round-robin ring.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Rotating-priority pick: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the winner.
//
// Ports:
//   req    : request vector, one bit per requester
//   ptr    : index holding highest priority this round
//   winner : chosen index (0 when nothing requests)
//   any    : at least one request is set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] rot;
  int             w;

  always_comb begin
    // After the shift, bit k of rot is req[(ptr + k) mod N].
    rot    = {req, req} >> ptr;
    winner = '0;
    any    = 1'b0;
    w      = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        w   = int'(ptr) + k;
        if (w >= N) begin
          w = w - N;
        end
        winner = IW'(w);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for one UART TX FIFO write port, with stall watchdog.
// Latency: grant 1 cycle after req_valid seen; bytes pass through combinationally while owned.
// Backpressure: uart_tx_fifo_full drops the owner's req_ready; full cycles never count as stalls.
//
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   req_data/valid/last, req_ready: per-requester byte streams (lane i at [8*i+7:8*i])
//   uart_tx_fifo_din/wr_en/full   : TX FIFO write side
//   grant_id                      : current/last owner index
//   busy                          : high while a packet is in flight
//   timeout_err                   : one-cycle pulse on the bit of an aborted owner
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [BYTE_W-1:0]          uart_tx_fifo_din,
  output logic                       uart_tx_fifo_wr_en,
  input  logic                       uart_tx_fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic [GW-1:0]     pick_id;
  logic              pick_any;
  logic [GW-1:0]     grant_nxt;
  logic              own_vld;
  logic              own_last;
  logic [BYTE_W-1:0] own_dat;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Owner's lane, selected by an explicit compare so every index stays constant.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_q) begin
        own_vld  = req_valid[i];
        own_last = req_last[i];
        own_dat  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
    // The finishing owner drops to lowest priority for the next round.
    grant_nxt = GW'(wrap_inc(int'(grant_q), NUM_REQ));
  end

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    rr_ptr_d           = rr_ptr_q;
    stall_cnt_d        = stall_cnt_q;
    req_ready          = '0;
    uart_tx_fifo_wr_en = 1'b0;
    uart_tx_fifo_din   = '0;
    timeout_err        = '0;

    case (state_q)
      ST_IDLE: begin
        // No byte moves here; the winner is registered and served next cycle.
        if (pick_any) begin
          grant_d     = pick_id;
          stall_cnt_d = '0;
          state_d     = ST_XFER;
        end
      end

      ST_XFER: begin
        req_ready[grant_q] = ~uart_tx_fifo_full;
        uart_tx_fifo_wr_en = own_vld & ~uart_tx_fifo_full;
        uart_tx_fifo_din   = own_dat;

        if (own_vld && !uart_tx_fifo_full) begin
          stall_cnt_d = '0;
          if (own_last) begin
            rr_ptr_d = grant_nxt;
            state_d  = ST_IDLE;
          end
        end else if (!own_vld && !uart_tx_fifo_full) begin
          // Owner went quiet while the FIFO had room: a genuine stall.
          if (stall_cnt_q == STALL_LIMIT) begin
            timeout_err[grant_q] = 1'b1;
            rr_ptr_d             = grant_nxt;
            stall_cnt_d          = '0;
            state_d              = ST_IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-level requester/arbiter model.
// Latency: n/a.
// Backpressure: random and forced FIFO-full windows.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      din;
  logic            wr_en;
  logic            full;
  logic [1:0]      grant_id;
  logic            busy;
  logic [NR-1:0]   timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .req_data           (req_data),
    .req_valid          (req_valid),
    .req_last           (req_last),
    .req_ready          (req_ready),
    .uart_tx_fifo_din   (din),
    .uart_tx_fifo_wr_en (wr_en),
    .uart_tx_fifo_full  (full),
    .grant_id           (grant_id),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner (-1 when idle), ring pointer, last grant, stall run length.
  int m_owner, m_ptr, m_gid, m_stall;
  // Requesters: bytes left in packet, byte on offer, offered-but-unaccepted, packet begun.
  int         rem[NR];
  logic [7:0] cur[NR];
  bit         pend[NR];
  bit         started[NR];
  int         last_acc_cyc[NR];
  // Stimulus knobs.
  logic [NR-1:0] gen_mask;
  int gen_pct, gap_pct, full_pct, stall_req;
  bit force_full;
  // Observations of the DUT.
  int         gq[$];
  int         iq[$];
  logic [7:0] wq[$];
  logic [7:0] sq[$];
  int wcnt, to_total, dut_to_cyc, cyc, idle_run;
  bit busy_prev;
  logic [NR-1:0] rdy_or;

  task automatic load_pkt(input int i, input int len);
    rem[i]     = len;
    cur[i]     = 8'($urandom);
    started[i] = 1'b0;
  endtask

  task automatic set_knobs(input logic [NR-1:0] gm, input int gp, input int gapp, input int fp);
    gen_mask = gm;
    gen_pct  = gp;
    gap_pct  = gapp;
    full_pct = fp;
  endtask

  task automatic step();
    logic [NR-1:0]   v, l, e_rdy, e_to;
    logic [8*NR-1:0] d;
    logic            f, e_wr, e_busy;
    logic [7:0]      e_din;
    int              g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (rem[i] == 0 && gen_mask[i] && $urandom_range(99) < gen_pct) load_pkt(i, $urandom_range(1, 4));
      if (pend[i]) v[i] = 1'b1;
      else if (rem[i] == 0) v[i] = 1'b0;
      else if (stall_req == i && started[i]) v[i] = 1'b0;
      else if (m_owner == i && $urandom_range(99) < gap_pct) v[i] = 1'b0;
      else v[i] = 1'b1;
      d[8*i +: 8] = cur[i];
      l[i] = (rem[i] == 1);
    end
    f = force_full || ($urandom_range(99) < full_pct);
    req_valid = v;
    req_data  = d;
    req_last  = l;
    full      = f;
    #1;
    e_rdy  = '0;
    e_to   = '0;
    e_wr   = 1'b0;
    e_din  = '0;
    e_busy = (m_owner >= 0);
    g      = m_owner;
    if (g >= 0) begin
      e_rdy[g] = !f;
      e_wr     = v[g] && !f;
      e_din    = d[8*g +: 8];
      e_to[g]  = !v[g] && !f && (m_stall == TO - 1);
    end
    check_eq("ready", req_ready, e_rdy);
    check_eq("wr_en", wr_en, e_wr);
    check_eq("din", din, e_din);
    check_eq("busy", busy, e_busy);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("timeout_err", timeout_err, e_to);

    if (wr_en) begin
      wcnt++;
      wq.push_back(din);
    end
    if (|timeout_err) begin
      to_total++;
      dut_to_cyc = cyc;
    end
    rdy_or = rdy_or | req_ready;
    if (busy && !busy_prev) begin
      gq.push_back(int'(grant_id));
      iq.push_back(idle_run);
    end
    idle_run  = busy ? 0 : idle_run + 1;
    busy_prev = busy;

    for (int i = 0; i < NR; i++) pend[i] = v[i];
    if (g < 0) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (m_owner < 0 && v[idx]) begin
          m_owner = idx;
          m_gid   = idx;
          m_stall = 0;
        end
      end
    end else if (e_wr) begin
      sq.push_back(cur[g]);
      pend[g]    = 1'b0;
      started[g] = 1'b1;
      rem[g]--;
      cur[g]     = 8'($urandom);
      last_acc_cyc[g] = cyc;
      m_stall    = 0;
      if (rem[g] == 0) begin
        m_ptr   = (g + 1) % NR;
        m_owner = -1;
      end
    end else if (!v[g] && !f) begin
      if (e_to[g]) begin
        rem[g]  = 0;
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NR;
        m_owner = -1;
        m_stall = 0;
      end else begin
        m_stall++;
      end
    end
  endtask

  // Asserts reset with inputs still driven, checks outputs immediately, then clears everything.
  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    for (int i = 0; i < NR; i++) begin
      rem[i]     = 0;
      pend[i]    = 1'b0;
      started[i] = 1'b0;
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full      = 1'b0;
    m_owner   = -1;
    m_ptr     = 0;
    m_gid     = 0;
    m_stall   = 0;
    busy_prev = 1'b0;
    idle_run  = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain(input string tag);
    bit done;
    set_knobs('0, 0, 0, 0);
    force_full = 1'b0;
    stall_req  = -1;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      done = (m_owner < 0) && !busy;
      for (int i = 0; i < NR; i++) if (rem[i] != 0) done = 1'b0;
    end
    check_eq(tag, done, 1);
  endtask

  initial begin
    int w0, t0;
    rstn       = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    full       = 1'b0;
    force_full = 1'b0;
    stall_req  = -1;
    rdy_or     = '0;
    set_knobs('0, 0, 0, 0);
    apply_reset();

    // Single 3-byte packet from requester 0.
    sq.delete(); wq.delete(); gq.delete();
    w0 = wcnt;
    load_pkt(0, 3);
    repeat (8) step();
    check_eq("a_wr_count", wcnt - w0, 3);
    check_eq("a_wq_size", wq.size(), 3);
    for (int i = 0; i < 3; i++) check_eq("a_byte", (i < wq.size()) ? wq[i] : 8'hxx, sq[i]);
    check_eq("a_grants", gq.size(), 1);
    check_eq("a_grant0", (gq.size() > 0) ? gq[0] : -1, 0);
    check_eq("a_busy_end", busy, 0);

    // All four requesters with 2-byte packets from a fresh pointer.
    apply_reset();
    sq.delete(); wq.delete(); gq.delete();
    w0 = wcnt;
    for (int i = 0; i < NR; i++) load_pkt(i, 2);
    repeat (20) step();
    check_eq("b_grants", gq.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("b_order", (i < gq.size()) ? gq[i] : -1, i);
    check_eq("b_wr_count", wcnt - w0, 8);
    for (int i = 0; i < 8; i++) check_eq("b_stream", (i < wq.size()) ? wq[i] : 8'hxx, sq[i]);

    // FIFO full for 5 cycles in the middle of requester 1's packet.
    load_pkt(1, 4);
    for (int n = 0; n < 20 && rem[1] != 2; n++) step();
    check_eq("c_reach_mid", rem[1], 2);
    w0 = wcnt; t0 = to_total; rdy_or = '0;
    force_full = 1'b1;
    repeat (5) step();
    force_full = 1'b0;
    check_eq("c_no_wr_full", wcnt - w0, 0);
    check_eq("c_no_ready_full", rdy_or[1], 0);
    check_eq("c_no_timeout", to_total - t0, 0);
    w0 = wcnt;
    repeat (6) step();
    check_eq("c_resume", wcnt - w0, 2);

    // Requester 2 stalls after one byte; requester 3 waits behind it.
    apply_reset();
    to_total = 0;
    load_pkt(2, 3);
    stall_req = 2;
    for (int n = 0; n < 10 && !started[2]; n++) step();
    check_eq("d_started", started[2], 1);
    load_pkt(3, 2);
    gq.delete();
    repeat (24) step();
    check_eq("d_timeouts", to_total, 1);
    check_eq("d_delay", dut_to_cyc - last_acc_cyc[2], 16);
    check_eq("d_next_grant", (gq.size() > 0) ? gq[0] : -1, 3);
    stall_req = -1;
    drain("d_drain");

    // Only requester 1, back to back.
    gq.delete(); iq.delete();
    set_knobs(4'b0010, 100, 0, 0);
    repeat (30) step();
    check_eq("e_enough_pkts", gq.size() >= 5, 1);
    foreach (gq[i]) check_eq("e_regrant", gq[i], 1);
    for (int i = 1; i < iq.size(); i++) check_eq("e_idle_gap", iq[i], 1);
    drain("e_drain");

    // Reset in the middle of a packet, then arbitration from pointer 0.
    load_pkt(0, 4);
    for (int n = 0; n < 20 && rem[0] != 2; n++) step();
    check_eq("f_reach_mid", rem[0], 2);
    apply_reset();
    gq.delete();
    load_pkt(1, 1);
    load_pkt(3, 1);
    repeat (8) step();
    check_eq("f_first", (gq.size() > 0) ? gq[0] : -1, 1);
    check_eq("f_second", (gq.size() > 1) ? gq[1] : -1, 3);

    // Randomized traffic against the model, then a whole-stream scoreboard check.
    apply_reset();
    sq.delete(); wq.delete();
    set_knobs(4'hF, 30, 20, 20);
    repeat (3000) step();
    drain("r_drain");
    check_eq("r_stream_len", wq.size(), sq.size());
    for (int i = 0; i < sq.size(); i++) check_eq("r_stream", (i < wq.size()) ? wq[i] : 8'hxx, sq[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
